// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: length header (LE 16-bit word count) followed by
// program bytes, assembled into little-endian 32-bit words; CPU is held in reset until done.
module imem_loader #(
  parameter int INS_ADDRESS_WIDTH = 12,
  parameter int DATA_WIDTH        = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         byte_valid,
  input  logic [7:0]                   byte_data,
  output logic                         byte_ready,
  output logic                         imem_we,
  output logic [INS_ADDRESS_WIDTH-1:0] imem_waddr,
  output logic [DATA_WIDTH-1:0]        imem_wdata,
  output logic                         cpu_rst,
  output logic                         done,
  output logic                         err
);

  localparam int          WIDX_W = INS_ADDRESS_WIDTH - 1;
  localparam logic [16:0] CAP    = 17'(1) << (INS_ADDRESS_WIDTH - 2);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_FLUSH, S_DONE, S_ERR
  } state_t;

  state_t                         state_q, state_d;
  logic [15:0]                    len_q, len_d;
  logic [1:0]                     byte_cnt_q, byte_cnt_d;
  logic [WIDX_W-1:0]              word_idx_q, word_idx_d;
  logic [DATA_WIDTH-9:0]          word_q, word_d;
  logic                           imem_we_q, imem_we_d;
  logic [INS_ADDRESS_WIDTH-1:0]   imem_waddr_q, imem_waddr_d;
  logic [DATA_WIDTH-1:0]          imem_wdata_q, imem_wdata_d;

  logic        accept;
  logic [15:0] len_full;
  logic        last_word;

  assign accept    = byte_valid && byte_ready;
  assign len_full  = {byte_data, len_q[7:0]};
  // Word index is one bit wider than the address field so a full-capacity load compares cleanly.
  assign last_word = (17'(word_idx_q) + 17'd1) == {1'b0, len_q};

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_LEN_LO;
      S_LEN_LO: if (accept) state_d = S_LEN_HI;
      S_LEN_HI: begin
        if (accept) begin
          if (len_full == 16'd0)             state_d = S_DONE;
          else if ({1'b0, len_full} > CAP)   state_d = S_ERR;
          else                               state_d = S_DATA;
        end
      end
      S_DATA:   if (accept && byte_cnt_q == 2'd3 && last_word) state_d = S_FLUSH;
      S_FLUSH:  state_d = S_DONE;
      default:  state_d = state_q;
    endcase
  end

  always_comb begin
    byte_ready = 1'b0;
    cpu_rst    = 1'b1;
    done       = 1'b0;
    err        = 1'b0;
    case (state_q)
      S_LEN_LO, S_LEN_HI, S_DATA: byte_ready = 1'b1;
      S_DONE: begin
        cpu_rst = 1'b0;
        done    = 1'b1;
      end
      S_ERR:   err = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    len_d        = len_q;
    byte_cnt_d   = byte_cnt_q;
    word_idx_d   = word_idx_q;
    word_d       = word_q;
    imem_we_d    = 1'b0;
    imem_waddr_d = imem_waddr_q;
    imem_wdata_d = imem_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          byte_cnt_d = 2'd0;
          word_idx_d = '0;
          word_d     = '0;
        end
      end
      S_LEN_LO: if (accept) len_d[7:0]  = byte_data;
      S_LEN_HI: if (accept) len_d[15:8] = byte_data;
      S_DATA: begin
        if (accept) begin
          case (byte_cnt_q)
            2'd0: word_d[7:0]   = byte_data;
            2'd1: word_d[15:8]  = byte_data;
            2'd2: word_d[23:16] = byte_data;
            default: begin
              // The fourth byte goes straight to the write port; only three are buffered.
              imem_we_d    = 1'b1;
              imem_wdata_d = {byte_data, word_q};
              imem_waddr_d = {word_idx_q[INS_ADDRESS_WIDTH-3:0], 2'b00};
              word_idx_d   = word_idx_q + 1'b1;
              word_d       = '0;
            end
          endcase
          byte_cnt_d = byte_cnt_q + 2'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q        <= '0;
      byte_cnt_q   <= '0;
      word_idx_q   <= '0;
      word_q       <= '0;
      imem_we_q    <= 1'b0;
      imem_waddr_q <= '0;
      imem_wdata_q <= '0;
    end else begin
      len_q        <= len_d;
      byte_cnt_q   <= byte_cnt_d;
      word_idx_q   <= word_idx_d;
      word_q       <= word_d;
      imem_we_q    <= imem_we_d;
      imem_waddr_q <= imem_waddr_d;
      imem_wdata_q <= imem_wdata_d;
    end
  end

  assign imem_we    = imem_we_q;
  assign imem_waddr = imem_waddr_q;
  assign imem_wdata = imem_wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: expected memory writes are queued as stimulus is driven and
// compared in order whenever the loader pulses imem_we.
module tb_imem_loader;

  localparam int AW = 12;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_data = 8'h00;
  logic          byte_ready;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [DW-1:0] imem_wdata;
  logic          cpu_rst;
  logic          done;
  logic          err;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  logic [AW+DW-1:0] exp_q[$];

  imem_loader #(.INS_ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .cpu_rst    (cpu_rst),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard: every write pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        check_eq("unexpected_we", 32'(imem_waddr), 32'hFFFF_FFFF);
      end else begin
        logic [AW+DW-1:0] e;
        e = exp_q.pop_front();
        check_eq("waddr", 32'(imem_waddr), 32'(e[AW+DW-1:DW]));
        check_eq("wdata", imem_wdata, e[DW-1:0]);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; byte_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Presents one byte until it is accepted; returns 1 ns after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit r;
    int n;
    if (gaps) begin
      byte_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    byte_valid = 1'b1;
    byte_data  = b;
    n = 0;
    forever begin
      @(negedge clk) r = byte_ready;
      @(posedge clk); #1;
      if (r) break;
      n++;
      if (n > 50) begin
        check_eq("ready_timeout", 32'd0, 32'd1);
        break;
      end
    end
    byte_valid = 1'b0;
  endtask

  task automatic load_random(input int n, input bit gaps);
    logic [15:0] len;
    logic [31:0] w;
    len = 16'(n);
    send_byte(len[7:0], gaps);
    send_byte(len[15:8], gaps);
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      exp_q.push_back({AW'(i * 4), w});
      for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gaps);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] t1 [6];
    t1 = '{8'h01, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00};

    // Reset values
    do_reset();
    @(negedge clk);
    check_eq("rst_byte_ready", 32'(byte_ready), 32'd0);
    check_eq("rst_we", 32'(imem_we), 32'd0);
    check_eq("rst_waddr", 32'(imem_waddr), 32'd0);
    check_eq("rst_wdata", imem_wdata, 32'd0);
    check_eq("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);

    // Single word, latency to done
    pulse_start();
    exp_q.push_back({12'h000, 32'h0050_0093});
    for (int i = 0; i < 6; i++) send_byte(t1[i], 1'b0);
    @(negedge clk);
    check_eq("t1_we_pulse", 32'(imem_we), 32'd1);
    check_eq("t1_done_early", 32'(done), 32'd0);
    check_eq("t1_cpu_rst_early", 32'(cpu_rst), 32'd1);
    @(negedge clk);
    check_eq("t1_done", 32'(done), 32'd1);
    check_eq("t1_cpu_rst", 32'(cpu_rst), 32'd0);
    check_eq("t1_we_off", 32'(imem_we), 32'd0);
    check_eq("t1_q_empty", 32'(exp_q.size()), 32'd0);

    // Three words with random gaps
    do_reset();
    wr_cnt = 0;
    pulse_start();
    load_random(3, 1'b1);
    repeat (2) @(negedge clk);
    check_eq("t2_done", 32'(done), 32'd1);
    check_eq("t2_writes", 32'(wr_cnt), 32'd3);
    check_eq("t2_q_empty", 32'(exp_q.size()), 32'd0);

    // Zero-length program, then start/bytes ignored in DONE
    do_reset();
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    @(negedge clk);
    check_eq("t3_done", 32'(done), 32'd1);
    check_eq("t3_cpu_rst", 32'(cpu_rst), 32'd0);
    check_eq("t3_ready", 32'(byte_ready), 32'd0);
    @(posedge clk); #1;
    start = 1'b1; byte_valid = 1'b1; byte_data = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("t6_done_hold", 32'(done), 32'd1);
      check_eq("t6_ready", 32'(byte_ready), 32'd0);
      check_eq("t6_err", 32'(err), 32'd0);
    end
    start = 1'b0; byte_valid = 1'b0;

    // Oversized header -> error
    do_reset();
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h04, 1'b0);
    byte_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("t4_err", 32'(err), 32'd1);
      check_eq("t4_cpu_rst", 32'(cpu_rst), 32'd1);
      check_eq("t4_ready", 32'(byte_ready), 32'd0);
      check_eq("t4_done", 32'(done), 32'd0);
    end
    byte_valid = 1'b0;

    // Full-capacity load, back-to-back bytes
    do_reset();
    wr_cnt = 0;
    pulse_start();
    load_random(1024, 1'b0);
    repeat (2) @(negedge clk);
    check_eq("t4_full_done", 32'(done), 32'd1);
    check_eq("t4_full_last_addr", 32'(imem_waddr), 32'hFFC);
    check_eq("t4_full_writes", 32'(wr_cnt), 32'd1024);
    check_eq("t4_full_q_empty", 32'(exp_q.size()), 32'd0);

    // Reset mid-load, then a fresh load
    do_reset();
    pulse_start();
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    exp_q.push_back({12'h000, 32'hDDCC_BBAA});
    send_byte(8'hAA, 1'b0); send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b0); send_byte(8'hDD, 1'b0);
    send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_eq("t5_we", 32'(imem_we), 32'd0);
    check_eq("t5_waddr", 32'(imem_waddr), 32'd0);
    check_eq("t5_wdata", imem_wdata, 32'd0);
    check_eq("t5_cpu_rst", 32'(cpu_rst), 32'd1);
    check_eq("t5_done", 32'(done), 32'd0);
    check_eq("t5_ready", 32'(byte_ready), 32'd0);
    check_eq("t5_q_empty", 32'(exp_q.size()), 32'd0);
    // A byte offered alongside start in IDLE must not be consumed as the header.
    @(posedge clk); #1;
    start = 1'b1; byte_valid = 1'b1; byte_data = 8'h07;
    @(posedge clk); #1;
    start = 1'b0; byte_valid = 1'b0;
    wr_cnt = 0;
    load_random(1, 1'b0);
    repeat (2) @(negedge clk);
    check_eq("t5_new_done", 32'(done), 32'd1);
    check_eq("t5_new_writes", 32'(wr_cnt), 32'd1);
    check_eq("t5_new_q_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
